// File: rtl/mem_arbiter.sv
// mem_arbiter
// -----------
// Shares one single-ported memory block between the instruction-fetch
// port (I) and the load/store data port (D). The memory accepts one
// access per cycle and returns read data one cycle later.
//
// Arbitration: D has priority over I. I is forced to win once it has
// lost STARVE_LIMIT consecutive cycles. A misaligned D access is granted
// but never reaches the memory. Instead, an error response is returned
// on the D port in the following cycle.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   i_req/i_addr        fetch request; i_gnt accepts it
//   i_rvalid/i_rdata    fetch response, one cycle after i_gnt
//   d_req/d_we/d_funct3/d_addr/d_wdata
//                       load/store request; d_gnt accepts it
//   d_rvalid/d_rdata/d_err
//                       load response or misalignment error
//   mem_*               connection to the memory block
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_write,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_write_data,
    output logic [31:0] mem_read_address,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        RESP_NONE = 2'b00,
        RESP_I    = 2'b01,
        RESP_D    = 2'b10
    } resp_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // A halfword must sit on an even address and a word on a multiple of
    // four. Byte accesses are never misaligned.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic mis;
        case (f3[1:0])
            2'b10:   mis = (a != 2'b00);
            2'b01:   mis = a[0];
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    logic [3:0]  starve_cnt_r;
    logic [3:0]  starve_cnt_s;
    resp_e       resp_port_r;
    resp_e       resp_port_s;
    logic        err_pend_r;
    logic        err_pend_s;
    logic [31:0] last_iaddr_r;
    logic [31:0] last_iaddr_s;
    logic        i_win_s;
    logic        d_win_s;
    logic        d_mis_s;

    // Request selection. Both grants are held low while reset is asserted.
    always_comb begin
        i_win_s = 1'b0;
        d_win_s = 1'b0;
        d_mis_s = is_misaligned(d_funct3, d_addr[1:0]);
        if (!rst_n) begin
            i_win_s = 1'b0;
            d_win_s = 1'b0;
        end else begin
            i_win_s = i_req && (!d_req || (starve_cnt_r == LIMIT));
            d_win_s = d_req && !i_win_s;
        end
        i_gnt = i_win_s;
        d_gnt = d_win_s;
    end

    // Memory request. When the memory is idle, both addresses park on the
    // last fetch address. This is harmless because reads have no side effects.
    always_comb begin
        mem_write         = 1'b0;
        mem_funct3        = 3'b010;
        mem_write_address = last_iaddr_r;
        mem_write_data    = 32'h0000_0000;
        mem_read_address  = last_iaddr_r;
        if (i_win_s) begin
            mem_read_address  = i_addr;
            mem_write_address = i_addr;
        end else if (d_win_s && !d_mis_s) begin
            mem_funct3 = d_funct3;
            if (d_we) begin
                mem_write         = 1'b1;
                mem_write_address = d_addr;
                mem_write_data    = d_wdata;
            end else begin
                mem_read_address = d_addr;
            end
        end else begin
            mem_write = 1'b0;
        end
    end

    // Next-state logic: starvation counter, response routing and error flag.
    always_comb begin
        starve_cnt_s = starve_cnt_r;
        resp_port_s  = RESP_NONE;
        err_pend_s   = d_win_s && d_mis_s;
        last_iaddr_s = last_iaddr_r;
        if (!i_req || i_win_s) begin
            starve_cnt_s = 4'd0;
        end else if (starve_cnt_r < LIMIT) begin
            starve_cnt_s = starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_s = starve_cnt_r;
        end
        if (i_win_s) begin
            resp_port_s  = RESP_I;
            last_iaddr_s = i_addr;
        end else if (d_win_s && !d_we && !d_mis_s) begin
            resp_port_s = RESP_D;
        end else begin
            resp_port_s = RESP_NONE;
        end
    end

    // State registers. Reset drops any response that is still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= 4'd0;
            resp_port_r  <= RESP_NONE;
            err_pend_r   <= 1'b0;
            last_iaddr_r <= 32'h0000_0000;
        end else begin
            starve_cnt_r <= starve_cnt_s;
            resp_port_r  <= resp_port_s;
            err_pend_r   <= err_pend_s;
            last_iaddr_r <= last_iaddr_s;
        end
    end

    // Response steering. The memory's registered read data passes straight
    // through to the port that owns this cycle's response. The other port
    // sees zero.
    always_comb begin
        i_rvalid = 1'b0;
        i_rdata  = 32'h0000_0000;
        d_rvalid = err_pend_r;
        d_rdata  = 32'h0000_0000;
        d_err    = err_pend_r;
        case (resp_port_r)
            RESP_I: begin
                i_rvalid = 1'b1;
                i_rdata  = mem_read_data;
            end
            RESP_D: begin
                d_rvalid = 1'b1;
                d_rdata  = mem_read_data;
            end
            default: begin
                i_rvalid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_write;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_write_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_address;
    logic [31:0] mem_read_data;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } d_exp_t;

    logic [31:0] exp_i_q[$];
    d_exp_t      exp_d_q[$];

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_write(mem_write), .mem_funct3(mem_funct3),
        .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
        .mem_read_address(mem_read_address), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Memory block model: 64 words plus the blue PWM duty register at 0xFFFFFFFC.
    logic [31:0] mem [0:63];
    logic [31:0] pwm_blue;
    logic [31:0] rd_q;
    logic        load_init;

    function automatic logic [31:0] mem_load(input logic [31:0] w, input logic [1:0] a,
                                             input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a +: 8];
        h = w[16*a[1] +: 16];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    always @(posedge clk) begin
        if (load_init) begin
            for (int j = 0; j < 64; j++) mem[j] <= 32'h0;
            mem[4]   <= 32'hDEAD_BEEF;
            mem[5]   <= 32'hCAFE_F00D;
            mem[10]  <= 32'h0000_0080;
            pwm_blue <= 32'h0;
            rd_q     <= 32'h0;
        end else begin
            if (mem_write) begin
                if (mem_write_address == 32'hFFFF_FFFC) pwm_blue <= mem_write_data;
                else case (mem_funct3[1:0])
                    2'b00:   mem[mem_write_address[7:2]][8*mem_write_address[1:0] +: 8] <= mem_write_data[7:0];
                    2'b01:   mem[mem_write_address[7:2]][16*mem_write_address[1] +: 16] <= mem_write_data[15:0];
                    default: mem[mem_write_address[7:2]] <= mem_write_data;
                endcase
            end
            rd_q <= mem_load((mem_read_address == 32'hFFFF_FFFC) ? pwm_blue : mem[mem_read_address[7:2]],
                             mem_read_address[1:0], mem_funct3);
        end
    end
    assign mem_read_data = rd_q;

    // Requester obligations.
    assert property (@(posedge clk) disable iff (!rst_n)
        (d_req && !d_gnt) |=> ($stable(d_we) && $stable(d_addr) && $stable(d_wdata) && $stable(d_funct3)));
    assert property (@(posedge clk) disable iff (!rst_n) (i_req && !i_gnt) |=> $stable(i_addr));
    assert property (@(posedge clk) disable iff (!rst_n)
        (d_req && d_we) |-> (d_funct3 inside {3'b000, 3'b001, 3'b010}));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every response the DUT presents must match the next queued expectation.
    always @(negedge clk) begin
        if (i_rvalid) begin
            if (exp_i_q.size() == 0) check("i_rvalid_unexpected", 32'(i_rvalid), 32'd0);
            else check("i_rdata", i_rdata, exp_i_q.pop_front());
        end
        if (d_rvalid) begin
            if (exp_d_q.size() == 0) check("d_rvalid_unexpected", 32'(d_rvalid), 32'd0);
            else begin
                d_exp_t e;
                e = exp_d_q.pop_front();
                check("d_err", 32'(d_err), 32'(e.err));
                check("d_rdata", d_rdata, e.data);
            end
        end
    end

    // Issue one D access, wait for its grant and queue the expected response.
    task automatic d_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_data);
        logic got;
        d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wdata;
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk); #1;
            if (d_gnt) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("d_gnt", 32'(got), 32'd1);
        if (got) begin
            check("d_mem_write", 32'(mem_write), 32'(we && !exp_err));
            if (!exp_err && we) begin
                check("d_wr_addr", mem_write_address, addr);
                check("d_wr_data", mem_write_data, wdata);
                check("d_wr_f3", 32'(mem_funct3), 32'(f3));
            end else if (!exp_err) begin
                check("d_rd_addr", mem_read_address, addr);
                check("d_rd_f3", 32'(mem_funct3), 32'(f3));
            end
            if (exp_err || !we) exp_d_q.push_back('{err: exp_err, data: exp_data});
            @(posedge clk); #1;
        end
    endtask

    task automatic idle_cycles(input int n);
        i_req = 1'b0; d_req = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; load_init = 1'b1;
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 32'h30; d_wdata = 32'h0;

        // Reset state: no grants and no responses while reset is held.
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_i_gnt", 32'(i_gnt), 32'd0);
        check("rst_d_gnt", 32'(d_gnt), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_i_rvalid", 32'(i_rvalid), 32'd0);
        check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        check("rst_d_err", 32'(d_err), 32'd0);
        check("rst_starve", 32'(dut.starve_cnt_r), 32'd0);
        i_req = 1'b0; d_req = 1'b0; load_init = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // I only.
        i_req = 1'b1; i_addr = 32'h10;
        @(negedge clk); #1;
        check("ionly_i_gnt", 32'(i_gnt), 32'd1);
        check("ionly_d_gnt", 32'(d_gnt), 32'd0);
        check("ionly_rd_addr", mem_read_address, 32'h10);
        check("ionly_f3", 32'(mem_funct3), 32'(3'b010));
        exp_i_q.push_back(32'hDEAD_BEEF);
        @(posedge clk); #1;
        i_req = 1'b0;
        @(negedge clk); #1;
        check("ionly_d_rvalid", 32'(d_rvalid), 32'd0);
        idle_cycles(2);

        // Priority and starvation: D wins 4 cycles, then I, repeating.
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h14;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk); #1;
            check("prio_starve", 32'(dut.starve_cnt_r), 32'(k % 5));
            check("prio_i_gnt", 32'(i_gnt), 32'((k % 5) == 4));
            check("prio_d_gnt", 32'(d_gnt), 32'((k % 5) != 4));
            if ((k % 5) == 4) exp_i_q.push_back(32'hDEAD_BEEF);
            else exp_d_q.push_back('{err: 1'b0, data: 32'hCAFE_F00D});
            @(posedge clk); #1;
        end
        idle_cycles(2);

        // Store then loads of various widths.
        d_op(1'b1, 3'b010, 32'h20, 32'h1234_5678, 1'b0, 32'h0);
        d_op(1'b0, 3'b100, 32'h23, 32'h0, 1'b0, 32'h0000_0012);
        d_op(1'b0, 3'b001, 32'h22, 32'h0, 1'b0, 32'h0000_1234);
        d_op(1'b0, 3'b000, 32'h28, 32'h0, 1'b0, 32'hFFFF_FF80);
        idle_cycles(2);

        // Misaligned accesses produce errors and leave memory untouched.
        d_op(1'b0, 3'b010, 32'h21, 32'h0, 1'b1, 32'h0);
        d_op(1'b1, 3'b001, 32'h21, 32'h0000_BEEF, 1'b1, 32'h0);
        idle_cycles(2);
        check("mis_mem_unchanged", mem[8], 32'h1234_5678);

        // Peripheral pass-through.
        d_op(1'b1, 3'b010, 32'hFFFF_FFFC, 32'h0000_00FF, 1'b0, 32'h0);
        idle_cycles(1);
        check("pwm_blue", pwm_blue, 32'h0000_00FF);
        d_op(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0000_00FF);
        idle_cycles(2);

        // Reset mid-flight: the granted fetch must never produce a response.
        i_req = 1'b1; i_addr = 32'h10;
        @(negedge clk); #1;
        check("midrst_i_gnt", 32'(i_gnt), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_i_gnt_low", 32'(i_gnt), 32'd0);
        d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 32'h30; d_wdata = 32'h55;
        #1;
        check("midrst_d_gnt_low", 32'(d_gnt), 32'd0);
        check("midrst_mem_write_low", 32'(mem_write), 32'd0);
        repeat (2) begin
            @(negedge clk); #1;
            check("inrst_i_gnt", 32'(i_gnt), 32'd0);
            check("inrst_d_gnt", 32'(d_gnt), 32'd0);
            check("inrst_mem_write", 32'(mem_write), 32'd0);
            check("inrst_i_rvalid", 32'(i_rvalid), 32'd0);
        end
        #1 rst_n = 1'b1;
        #1;
        check("postrst_starve", 32'(dut.starve_cnt_r), 32'd0);
        check("postrst_d_gnt", 32'(d_gnt), 32'd1);
        check("postrst_i_gnt", 32'(i_gnt), 32'd0);
        check("postrst_mem_write", 32'(mem_write), 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk); #1;
        check("postrst_starve1", 32'(dut.starve_cnt_r), 32'd1);
        check("postrst_i_gnt2", 32'(i_gnt), 32'd1);
        exp_i_q.push_back(32'hDEAD_BEEF);
        @(posedge clk); #1;
        idle_cycles(3);
        check("postrst_store", mem[12], 32'h0000_0055);

        check("i_queue_drained", 32'(exp_i_q.size()), 32'd0);
        check("d_queue_drained", 32'(exp_d_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Global time limit.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single `memory` block (one access per cycle, 1-cycle registered read) between the instruction-fetch port (I) and the load/store data port (D).
- Selects one requester per cycle and drives the memory address, data, funct3 and write_mem.
- Routes the returned read_data to the winning port one cycle later.
- Rejects misaligned data accesses with an error response instead of issuing them.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles I may lose to D before I is forced to win. Legal range 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held with i_addr until i_gnt
- i_addr  in  32  fetch address (word aligned)
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  i_rdata valid
- i_rdata  out  32  fetched word
- d_req  in  1  data request; held with d_we, d_addr, d_wdata, d_funct3 until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_funct3  in  3  RV32I width/sign code
- d_addr  in  32  data address
- d_wdata  in  32  store data (LSB-justified for sb/sh)
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data or error response valid
- d_rdata  out  32  load data
- d_err  out  1  qualifies d_rvalid: misaligned access rejected
- mem_write  out  1  to memory write_mem
- mem_funct3  out  3  to memory funct3
- mem_write_address  out  32  to memory write_address
- mem_write_data  out  32  to memory write_data
- mem_read_address  out  32  to memory read_address
- mem_read_data  in  32  from memory read_data

Behaviour:
- Reset (rst_n low, async): starve_cnt=0, resp_port=NONE, err_pend=0. i_rvalid, d_rvalid, d_err = 0.
- While rst_n is low, i_gnt, d_gnt and mem_write are forced 0 combinationally.
- Arbitration is combinational within a cycle; at most one gnt per cycle.
- Default priority: D over I.
- I wins if i_req and (!d_req or starve_cnt == STARVE_LIMIT).
- starve_cnt increments (saturating at STARVE_LIMIT) on each cycle i_req is high and i_gnt is low. It clears on i_gnt or when !i_req.
- Misaligned D access:
  - Definition: funct3[1:0]=2'b10 with addr[1:0]!=0, or funct3[1:0]=2'b01 with addr[0]!=0.
  - Still granted (d_gnt=1), but mem_write=0 and nothing is driven to memory.
  - Next cycle: d_rvalid=1, d_err=1, d_rdata=0.
- I grant: mem_read_address=i_addr, mem_funct3=3'b010, mem_write=0.
- D load grant: mem_read_address=d_addr, mem_funct3=d_funct3, mem_write=0.
- D store grant: mem_write_address=d_addr, mem_write_data=d_wdata, mem_funct3=d_funct3, mem_write=1. Stores produce no rvalid.
- No grant: mem_write=0, mem_funct3=3'b010, addresses hold the last I address. This is harmless because reads have no side effects.
- Read latency is exactly 1 cycle:
  - A read granted in cycle N sets resp_port (registered).
  - In cycle N+1, the selected port's rvalid=1 and its rdata=mem_read_data (combinational pass-through).
  - The other port's rdata is 0.
- rdata is valid only while rvalid is high; it is not held.
- Back-to-back grants are allowed every cycle, and the requesters may alternate freely.
- A read granted in cycle N+1 does not disturb the response delivered in N+1.
- A store in cycle N followed by a load of the same address in N+1 returns the stored value: the write lands at the N edge, the read samples at the N+1 edge.
- Reset asserted mid-operation: a pending response is dropped (no rvalid after deassertion) and starve_cnt restarts at 0.
- Requester obligations (assertions in the bench, not checked by RTL):
  - A requester must not change its request fields while req is high and gnt is low.
  - d_we=1 is only legal with funct3 in {000, 001, 010}.

Test Plan:
- I only: i_req=1, i_addr=0x10 with mem[4]=0xDEADBEEF → i_gnt same cycle; i_rvalid=1 and i_rdata=0xDEADBEEF next cycle; d_rvalid stays 0.
- Priority/starvation (STARVE_LIMIT=4): i_req and d_req held high continuously → D granted 4 cycles, I on the 5th, D for 4 more, repeating; starve_cnt observed saturating at 4.
- Store then load: sw 0x12345678 at 0x20, then lbu 0x23 on the next cycle → d_rvalid with d_rdata=0x00000012. Then lh 0x22 → 0x00001234. Then lb from a byte holding 0x80 → 0xFFFFFF80.
- Misaligned: lw at 0x21 → d_gnt=1, mem_write=0 and no memory change; next cycle d_rvalid=1, d_err=1, d_rdata=0. Same for sh at 0x21.
- Peripheral pass-through: sw 0x000000FF to 0xFFFFFFFC → memory blue PWM duty becomes 0xFF. Then lw 0xFFFFFFFC → d_rdata=0x000000FF.
- Reset mid-flight: grant an I read, pull rst_n low before the next edge and release 2 cycles later → no i_rvalid, gnts and mem_write are 0 throughout reset, and arbitration resumes with starve_cnt=0.
